// File: rtl/debouncer_pkg.sv
// rtl/debouncer_pkg.sv - shared FSM state type and helpers for the switch debouncer array
package debouncer_pkg;

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } state_e;

  function automatic int stable_cycles(input int clk_rate, input int stable_hz);
    return clk_rate / stable_hz;
  endfunction

  // A channel reports high while settled high or while a fall is still being qualified.
  function automatic logic state_is_high(input state_e state);
    return (state == STABLE_HI) || (state == WAIT_LO);
  endfunction

endpackage

// File: rtl/debouncer_ch.sv
// rtl/debouncer_ch.sv - one switch channel: two-flop synchroniser, qualification FSM and edge ticks
module debouncer_ch
  import debouncer_pkg::*;
#(
  parameter int StableCycles = 10,
  parameter bit ResetLevel   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sw_i,
  input  logic en_i,
  output logic db_level_o,
  output logic db_rise_o,
  output logic db_fall_o
);

  localparam int CntW = $clog2(StableCycles);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntLast = CntW'(StableCycles - 1);
  localparam state_e ResetState = ResetLevel ? STABLE_HI : STABLE_LO;

  logic [1:0]      sync_q;
  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            level_q;
  logic            rise_q;
  logic            fall_q;
  logic            s;
  logic            state_high;

  assign s          = sync_q[1];
  assign state_high = state_is_high(state_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= {2{ResetLevel}};
      state_q <= ResetState;
      cnt_q   <= '0;
      level_q <= ResetLevel;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sw_i};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (!en_i) begin
        // Disabled: pin the FSM to whatever level the outside world currently sees.
        state_q <= level_q ? STABLE_HI : STABLE_LO;
        cnt_q   <= '0;
      end else begin
        level_q <= state_high;
        rise_q  <= state_high & ~level_q;
        fall_q  <= ~state_high & level_q;
        case (state_q)
          STABLE_LO: begin
            if (s) begin
              state_q <= WAIT_HI;
              cnt_q   <= CntOne;
            end
          end
          WAIT_HI: begin
            if (!s) begin
              state_q <= STABLE_LO;
              cnt_q   <= '0;
            end else if (cnt_q == CntLast) begin
              state_q <= STABLE_HI;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CntOne;
            end
          end
          STABLE_HI: begin
            if (!s) begin
              state_q <= WAIT_LO;
              cnt_q   <= CntOne;
            end
          end
          WAIT_LO: begin
            if (s) begin
              state_q <= STABLE_HI;
              cnt_q   <= '0;
            end else if (cnt_q == CntLast) begin
              state_q <= STABLE_LO;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CntOne;
            end
          end
          default: begin
            state_q <= ResetState;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign db_level_o = level_q;
  assign db_rise_o  = rise_q;
  assign db_fall_o  = fall_q;

endmodule

// File: rtl/debouncer_array.sv
// rtl/debouncer_array.sv - array of independent switch debouncers with a combined tick output
module debouncer_array
  import debouncer_pkg::*;
#(
  parameter int NumCh      = 4,
  parameter int ClkRate    = 10_000_000,
  parameter int StableHz   = 1_000_000,
  parameter bit ResetLevel = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NumCh-1:0] sw_i,
  input  logic [NumCh-1:0] en_i,
  output logic [NumCh-1:0] db_level_o,
  output logic [NumCh-1:0] db_rise_o,
  output logic [NumCh-1:0] db_fall_o,
  output logic             any_tick_o
);

  localparam int StableCycles = stable_cycles(ClkRate, StableHz);

  if (StableCycles < 2) begin : g_bad_stable
    $error("debouncer_array: ClkRate/StableHz must be at least 2");
  end

  if ((NumCh < 1) || (NumCh > 32)) begin : g_bad_numch
    $error("debouncer_array: NumCh must be in 1..32");
  end

  for (genvar ch = 0; ch < NumCh; ch++) begin : g_ch
    debouncer_ch #(
      .StableCycles(StableCycles),
      .ResetLevel  (ResetLevel)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .sw_i      (sw_i[ch]),
      .en_i      (en_i[ch]),
      .db_level_o(db_level_o[ch]),
      .db_rise_o (db_rise_o[ch]),
      .db_fall_o (db_fall_o[ch])
    );
  end

  assign any_tick_o = |(db_rise_o | db_fall_o);

endmodule

// File: doc/debouncer_array.md
DEBOUNCER_ARRAY -- requirements
Module: debouncer_array

Interface
REQ-001 Parameter NumCh, default 4: number of independent switch channels, legal range 1..32.
REQ-002 Parameter ClkRate, default 10_000_000: clock frequency in Hz.
REQ-003 Parameter StableHz, default 1_000_000: reciprocal of the required stable time.
   - StableCycles = ClkRate/StableHz, integer division; default 10.
   - Elaboration SHALL fail if StableCycles < 2.
REQ-004 Parameter ResetLevel, default 0: db_level_o value per channel after reset.
REQ-005 clk_i  input  1  system clock; single clock domain.
REQ-006 rst_ni  input  1  reset; asynchronous assert, active-low.
REQ-007 sw_i  input  NumCh  raw asynchronous switch inputs.
REQ-008 en_i  input  NumCh  per-channel enable; synchronous to clk_i.
REQ-009 db_level_o  output  NumCh  debounced level per channel.
REQ-010 db_rise_o  output  NumCh  one-cycle pulse on a debounced 0->1 change.
REQ-011 db_fall_o  output  NumCh  one-cycle pulse on a debounced 1->0 change.
REQ-012 any_tick_o  output  1  OR of all db_rise_o and db_fall_o bits, same cycle.

Function
REQ-013 Each sw_i bit SHALL pass through a two-flop synchroniser; its output is s[i].
REQ-014 Each channel SHALL run its own four-state FSM:
   - STABLE_LO: if s=1, go to WAIT_HI with count=1.
   - WAIT_HI: if s=0, go to STABLE_LO with count=0; else if count=StableCycles-1, go to STABLE_HI; else count+1.
   - STABLE_HI: if s=0, go to WAIT_LO with count=1.
   - WAIT_LO: symmetric to WAIT_HI, returning to STABLE_HI on a glitch.
REQ-015 db_level_o[i] SHALL be 1 in STABLE_HI and WAIT_LO, and 0 in STABLE_LO and WAIT_HI.
   - The output is registered from the state; no combinational path from sw_i.
REQ-016 Latency: a clean sw_i edge SHALL produce the db_level_o change exactly 2+StableCycles clock edges after the first edge that samples the new sw_i value.
REQ-017 A glitch on s shorter than StableCycles cycles SHALL produce no level change and no tick.
REQ-018 db_rise_o[i] SHALL be high for exactly the one cycle in which db_level_o[i] first reads 1; db_fall_o[i] likewise for the first 0.
REQ-019 The counter SHALL be $clog2(StableCycles) bits wide and SHALL never wrap; the terminal compare uses StableCycles-1.
REQ-020 en_i[i]=0 SHALL:
   - force the channel to the STABLE state matching its current db_level_o;
   - clear the counter;
   - suppress rise and fall pulses.
   The synchroniser keeps running while disabled.
REQ-021 On re-enable with s differing from db_level_o, the channel SHALL restart qualification from count=1.
REQ-022 Channels SHALL be fully independent; simultaneous ticks on several channels are legal and all are reported.

Reset
REQ-023 While rst_ni=0, all outputs SHALL assert their reset values immediately, without waiting for a clock edge:
   - synchronisers = ResetLevel;
   - state = STABLE_LO or STABLE_HI per ResetLevel;
   - counters = 0;
   - db_level_o = ResetLevel;
   - db_rise_o = db_fall_o = any_tick_o = 0.
REQ-024 Reset asserted mid-qualification SHALL discard the partial count.
   - No tick SHALL be generated on reset assertion or release.

Structure
REQ-025 Package debouncer_pkg SHALL hold:
   - the FSM state enum (STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO);
   - a function computing StableCycles from ClkRate and StableHz.
REQ-026 The per-channel logic (synchroniser, FSM, counter, tick) SHALL be a sub-module debouncer_ch.
   - debouncer_array instantiates NumCh copies of it in a generate loop and ORs the ticks.

Verification (defaults, StableCycles=10)
REQ-027 Reset: rst_ni=0 with clocks running -> db_level_o=4'h0 and all ticks 0; release -> no tick for 20 cycles.
REQ-028 Clean press: sw_i[0] 0->1 held -> db_level_o[0]=1 exactly 12 edges later; db_rise_o[0] and any_tick_o high for 1 cycle.
REQ-029 Bounce: sw_i[1] toggles with 3-cycle high and 2-cycle low periods for 40 cycles, then stays 1 -> exactly one db_rise_o[1], 12 edges after the final stable edge.
REQ-030 Release and a 9-cycle glitch:
   - a 9-cycle high pulse on sw_i[2] -> no change and no tick;
   - a 10-cycle pulse -> db_level_o[2] high for 10 cycles, with one rise and one fall.
REQ-031 Enable and reset mid-operation:
   - en_i[3]=0 during qualification -> no tick;
   - re-enable with sw_i[3]=1 held -> rise 10 cycles after re-enable;
   - rst_ni pulse at count=5 on channel 0 -> level stays at ResetLevel and no tick.
REQ-032 Parallelism: all four channels press on the same cycle -> db_rise_o=4'hF for one cycle and any_tick_o=1 for one cycle.
